// File: rtl/fetch_unit.sv
// fetch_unit
//
// IF-stage front end sitting directly upstream of the gshare branch
// predictor. Owns the PC, issues one instruction-memory request at a
// time, and fills the IF/ID pipeline register. Each fetched instruction
// travels with a snapshot of the prediction made for its PC.
//
// Optional feature: define FETCH_PERF_CNT_EN to add two free-running
// performance counters (fetches accepted, redirect cycles).
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   IF_PCnext_sel_i         next-PC select (00 PC+4, 01 EXMEM_pcplus4,
//                           10 BTB target, 11 EXMEM_br_target)
//   IF_flush_i              mispredict redirect
//   IF_btb_rd_target_i      BTB target for the current PC
//   IF_prediction_i         predicted-taken for the current PC
//   IF_btb_hit_i            BTB hit for the current PC
//   IF_ghr_data_i           GHR value used for the current PC
//   EXMEM_pcplus4_i         recovery PC, not-taken mispredict
//   EXMEM_br_target_i       recovery PC, taken mispredict
//   ID_stall_i              ID cannot accept; IF/ID holds
//   imem_rdata_i            instruction data
//   imem_rvalid_i           response valid (>= 1 cycle after request)
//   IF_pc_o                 current PC (predictor tag/index source)
//   imem_req_o, imem_addr_o request strobe and address
//   ID_valid_o, ID_pc_o, ID_instr_o,
//   ID_prediction_o, ID_btb_hit_o, ID_ghr_data_o   IF/ID register
//   perf_fetch_cnt_o, perf_redirect_cnt_o          (FETCH_PERF_CNT_EN only)

module fetch_unit #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          HISTORY_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [1:0]               IF_PCnext_sel_i,
    input  logic                     IF_flush_i,
    input  logic [31:0]              IF_btb_rd_target_i,
    input  logic                     IF_prediction_i,
    input  logic                     IF_btb_hit_i,
    input  logic [HISTORY_WIDTH-1:0] IF_ghr_data_i,
    input  logic [31:0]              EXMEM_pcplus4_i,
    input  logic [31:0]              EXMEM_br_target_i,
    input  logic                     ID_stall_i,
    input  logic [31:0]              imem_rdata_i,
    input  logic                     imem_rvalid_i,
    output logic [31:0]              IF_pc_o,
    output logic                     imem_req_o,
    output logic [31:0]              imem_addr_o,
    output logic                     ID_valid_o,
    output logic [31:0]              ID_pc_o,
    output logic [31:0]              ID_instr_o,
    output logic                     ID_prediction_o,
    output logic                     ID_btb_hit_o,
    output logic [HISTORY_WIDTH-1:0] ID_ghr_data_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]              perf_fetch_cnt_o,
    output logic [31:0]              perf_redirect_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD,
        S_DISCARD
    } state_t;

    state_t state_q, state_d;

    logic [31:0]              pc_q;

    // Side registers captured in the request cycle; they describe the
    // instruction currently in flight.
    logic [31:0]              snap_pc_q;
    logic [31:0]              snap_next_pc_q;
    logic                     snap_pred_q;
    logic                     snap_hit_q;
    logic [HISTORY_WIDTH-1:0] snap_ghr_q;

    // Hold buffer: a response that arrived while ID was stalled.
    logic [31:0]              hold_pc_q;
    logic [31:0]              hold_instr_q;
    logic                     hold_pred_q;
    logic                     hold_hit_q;
    logic [HISTORY_WIDTH-1:0] hold_ghr_q;

    logic id_can_accept;
    logic take_snapshot;
    logic load_id_mem;
    logic load_id_hold;
    logic load_hold;
    logic advance_pc;
    logic redirect;

    assign IF_pc_o       = pc_q;
    assign imem_addr_o   = pc_q;
    assign id_can_accept = !ID_valid_o || !ID_stall_i;

    // Next-state and control strobes. A flush overrides everything else;
    // the only thing it preserves is the knowledge that a response is still
    // outstanding, so that the stale data can be discarded on arrival.
    always_comb begin
        state_d       = state_q;
        imem_req_o    = 1'b0;
        take_snapshot = 1'b0;
        load_id_mem   = 1'b0;
        load_id_hold  = 1'b0;
        load_hold     = 1'b0;
        advance_pc    = 1'b0;
        redirect      = 1'b0;

        if (rst_i) begin
            state_d = S_IDLE;
        end else if (IF_flush_i) begin
            redirect = 1'b1;
            case (state_q)
                S_WAIT:    state_d = imem_rvalid_i ? S_IDLE : S_DISCARD;
                S_DISCARD: state_d = S_DISCARD;
                default:   state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    imem_req_o    = 1'b1;
                    take_snapshot = 1'b1;
                    state_d       = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        advance_pc = 1'b1;
                        if (id_can_accept) begin
                            load_id_mem = 1'b1;
                            state_d     = S_IDLE;
                        end else begin
                            load_hold = 1'b1;
                            state_d   = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!ID_stall_i) begin
                        load_id_hold = 1'b1;
                        state_d      = S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (imem_rvalid_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and PC register. The PC only moves when a response is taken
    // (to the target chosen back in the request cycle) or on a redirect.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (redirect) begin
                pc_q <= (IF_PCnext_sel_i == 2'b11) ? EXMEM_br_target_i : EXMEM_pcplus4_i;
            end else if (advance_pc) begin
                pc_q <= snap_next_pc_q;
            end
        end
    end

    // Request-cycle snapshot. Selects 01/11 only mean something alongside
    // a flush, so without one they fall back to sequential PC+4.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            snap_pc_q      <= '0;
            snap_next_pc_q <= '0;
            snap_pred_q    <= 1'b0;
            snap_hit_q     <= 1'b0;
            snap_ghr_q     <= '0;
        end else if (take_snapshot) begin
            snap_pc_q      <= pc_q;
            snap_next_pc_q <= (IF_PCnext_sel_i == 2'b10) ? IF_btb_rd_target_i : pc_q + 32'd4;
            snap_pred_q    <= IF_prediction_i;
            snap_hit_q     <= IF_btb_hit_i;
            snap_ghr_q     <= IF_ghr_data_i;
        end
    end

    // Hold buffer: parks a response while ID is stalled; a redirect
    // empties it.
    always_ff @(posedge clk_i) begin
        if (rst_i || redirect) begin
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
            hold_pred_q  <= 1'b0;
            hold_hit_q   <= 1'b0;
            hold_ghr_q   <= '0;
        end else if (load_hold) begin
            hold_pc_q    <= snap_pc_q;
            hold_instr_q <= imem_rdata_i;
            hold_pred_q  <= snap_pred_q;
            hold_hit_q   <= snap_hit_q;
            hold_ghr_q   <= snap_ghr_q;
        end
    end

    // IF/ID register. Valid drops on a redirect, or when ID consumes the
    // current entry and nothing new arrives to replace it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ID_valid_o      <= 1'b0;
            ID_pc_o         <= '0;
            ID_instr_o      <= '0;
            ID_prediction_o <= 1'b0;
            ID_btb_hit_o    <= 1'b0;
            ID_ghr_data_o   <= '0;
        end else begin
            if (redirect) begin
                ID_valid_o <= 1'b0;
            end else if (load_id_mem || load_id_hold) begin
                ID_valid_o <= 1'b1;
            end else if (!ID_stall_i) begin
                ID_valid_o <= 1'b0;
            end

            if (load_id_mem) begin
                ID_pc_o         <= snap_pc_q;
                ID_instr_o      <= imem_rdata_i;
                ID_prediction_o <= snap_pred_q;
                ID_btb_hit_o    <= snap_hit_q;
                ID_ghr_data_o   <= snap_ghr_q;
            end else if (load_id_hold) begin
                ID_pc_o         <= hold_pc_q;
                ID_instr_o      <= hold_instr_q;
                ID_prediction_o <= hold_pred_q;
                ID_btb_hit_o    <= hold_hit_q;
                ID_ghr_data_o   <= hold_ghr_q;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Performance counters: responses accepted (into IF/ID or the hold
    // buffer) and cycles spent under a redirect. Both wrap naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_fetch_cnt_o    <= '0;
            perf_redirect_cnt_o <= '0;
        end else begin
            if (load_id_mem || load_hold) begin
                perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
            end
            if (IF_flush_i) begin
                perf_redirect_cnt_o <= perf_redirect_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. A table of fetch records drives the
// straight-line fetch flow (sequential, BTB-taken, wrap, varied latency);
// hand-written sequences cover flush in WAIT, stall into HOLD, the
// flush+stall+rvalid collision and reset in the middle of WAIT. Expected
// IF/ID contents are pushed to a scoreboard queue when a request issues and
// popped when the instruction lands in IF/ID.

module tb_fetch_unit;

    localparam int          HW     = 8;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [1:0]    IF_PCnext_sel_i;
    logic          IF_flush_i;
    logic [31:0]   IF_btb_rd_target_i;
    logic          IF_prediction_i;
    logic          IF_btb_hit_i;
    logic [HW-1:0] IF_ghr_data_i;
    logic [31:0]   EXMEM_pcplus4_i;
    logic [31:0]   EXMEM_br_target_i;
    logic          ID_stall_i;
    logic [31:0]   imem_rdata_i;
    logic          imem_rvalid_i;
    logic [31:0]   IF_pc_o;
    logic          imem_req_o;
    logic [31:0]   imem_addr_o;
    logic          ID_valid_o;
    logic [31:0]   ID_pc_o;
    logic [31:0]   ID_instr_o;
    logic          ID_prediction_o;
    logic          ID_btb_hit_o;
    logic [HW-1:0] ID_ghr_data_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   perf_fetch_cnt_o;
    logic [31:0]   perf_redirect_cnt_o;
`endif

    // Free-running 10 ns clock.
    always #5 clk_i = ~clk_i;

    fetch_unit #(
        .RESET_PC      (RST_PC),
        .HISTORY_WIDTH (HW)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .IF_PCnext_sel_i    (IF_PCnext_sel_i),
        .IF_flush_i         (IF_flush_i),
        .IF_btb_rd_target_i (IF_btb_rd_target_i),
        .IF_prediction_i    (IF_prediction_i),
        .IF_btb_hit_i       (IF_btb_hit_i),
        .IF_ghr_data_i      (IF_ghr_data_i),
        .EXMEM_pcplus4_i    (EXMEM_pcplus4_i),
        .EXMEM_br_target_i  (EXMEM_br_target_i),
        .ID_stall_i         (ID_stall_i),
        .imem_rdata_i       (imem_rdata_i),
        .imem_rvalid_i      (imem_rvalid_i),
        .IF_pc_o            (IF_pc_o),
        .imem_req_o         (imem_req_o),
        .imem_addr_o        (imem_addr_o),
        .ID_valid_o         (ID_valid_o),
        .ID_pc_o            (ID_pc_o),
        .ID_instr_o         (ID_instr_o),
        .ID_prediction_o    (ID_prediction_o),
        .ID_btb_hit_o       (ID_btb_hit_o),
        .ID_ghr_data_o      (ID_ghr_data_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt_o    (perf_fetch_cnt_o),
        .perf_redirect_cnt_o (perf_redirect_cnt_o)
`endif
    );

    typedef struct {
        logic [1:0]    sel;
        logic          pred;
        logic          hit;
        logic [HW-1:0] ghr;
        logic [31:0]   target;
        int            lat;
        logic [31:0]   exp_addr;
    } vec_t;

    typedef struct {
        logic [31:0]   pc;
        logic [31:0]   instr;
        logic          pred;
        logic          hit;
        logic [HW-1:0] ghr;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   checks = 0;
    int   passes = 0;

    // Instruction memory contents: a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        IF_PCnext_sel_i    = 2'b00;
        IF_flush_i         = 1'b0;
        IF_btb_rd_target_i = 32'h0;
        IF_prediction_i    = 1'b0;
        IF_btb_hit_i       = 1'b0;
        IF_ghr_data_i      = '0;
        EXMEM_pcplus4_i    = 32'h0;
        EXMEM_br_target_i  = 32'h0;
        ID_stall_i         = 1'b0;
        imem_rdata_i       = 32'h0;
        imem_rvalid_i      = 1'b0;
    endtask

    // Waits (bounded) for a request and checks its address; waited is the
    // number of cycles spent before the request appeared.
    task automatic waitReq(input logic [31:0] exp_addr, input string name,
                           output int waited, output bit ok);
        ok     = 1'b0;
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (imem_req_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            waited++;
            tick();
        end
        if (!ok) begin
            checkOutput({name, "_req_timeout"}, 32'd0, 32'd1);
        end else begin
            checkOutput({name, "_req_addr"}, imem_addr_o, exp_addr);
        end
    endtask

    task automatic popCompare(input string name);
        exp_t e;
        checkOutput({name, "_id_valid"}, 32'(ID_valid_o), 32'd1);
        if (sb.size() == 0) begin
            checkOutput({name, "_sb_underflow"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            checkOutput({name, "_id_pc"},    ID_pc_o, e.pc);
            checkOutput({name, "_id_instr"}, ID_instr_o, e.instr);
            checkOutput({name, "_id_pred"},  32'(ID_prediction_o), 32'(e.pred));
            checkOutput({name, "_id_hit"},   32'(ID_btb_hit_o), 32'(e.hit));
            checkOutput({name, "_id_ghr"},   32'(ID_ghr_data_o), 32'(e.ghr));
        end
    endtask

    // One complete fetch with no stall: request, latency, response, ID check.
    // Predictor inputs are scrambled after the request cycle so only the
    // snapshot can produce the right IF/ID contents and next PC.
    task automatic applyStimulus(input vec_t v, input string tag);
        int waited;
        bit ok;
        idleInputs();
        IF_PCnext_sel_i    = v.sel;
        IF_prediction_i    = v.pred;
        IF_btb_hit_i       = v.hit;
        IF_ghr_data_i      = v.ghr;
        IF_btb_rd_target_i = v.target;
        waitReq(v.exp_addr, tag, waited, ok);
        if (!ok) return;
        checkOutput({tag, "_req_wait"}, 32'(waited), 32'd0);
        sb.push_back('{v.exp_addr, mem_word(v.exp_addr), v.pred, v.hit, v.ghr});
        tick();
        IF_PCnext_sel_i    = 2'b10;
        IF_btb_rd_target_i = 32'hBAD0_0000;
        IF_prediction_i    = ~v.pred;
        IF_btb_hit_i       = ~v.hit;
        IF_ghr_data_i      = ~v.ghr;
        for (int c = 1; c < v.lat; c++) begin
            tick();
            checkOutput({tag, "_bubble"}, 32'(ID_valid_o), 32'd0);
        end
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(v.exp_addr);
        tick();
        idleInputs();
        popCompare(tag);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        int waited;
        bit ok;

        //            sel    pred  hit   ghr    target        lat exp_addr
        vecs[0] = '{2'b00, 1'b0, 1'b0, 8'h11, 32'h0000_DEAD, 1, 32'h0000_0000};
        vecs[1] = '{2'b00, 1'b0, 1'b0, 8'h22, 32'h0000_0000, 1, 32'h0000_0004};
        vecs[2] = '{2'b10, 1'b1, 1'b1, 8'h5A, 32'h0000_0040, 1, 32'h0000_0008};
        vecs[3] = '{2'b00, 1'b0, 1'b0, 8'h33, 32'h0000_0000, 2, 32'h0000_0040};
        vecs[4] = '{2'b01, 1'b1, 1'b0, 8'h44, 32'h0000_0080, 1, 32'h0000_0044};
        vecs[5] = '{2'b11, 1'b0, 1'b1, 8'h55, 32'h0000_0090, 3, 32'h0000_0048};
        vecs[6] = '{2'b10, 1'b0, 1'b1, 8'h66, 32'hFFFF_FFFC, 1, 32'h0000_004C};
        vecs[7] = '{2'b00, 1'b1, 1'b1, 8'h77, 32'h0000_0000, 1, 32'hFFFF_FFFC};
        vecs[8] = '{2'b00, 1'b0, 1'b0, 8'h88, 32'h0000_0000, 1, 32'h0000_0000};

        // Reset
        idleInputs();
        rst_i = 1'b1;
        settle();
        checkOutput("rst_req_comb", 32'(imem_req_o), 32'd0);
        tick();
        checkOutput("rst_pc",       IF_pc_o, RST_PC);
        checkOutput("rst_id_valid", 32'(ID_valid_o), 32'd0);
        checkOutput("rst_id_pc",    ID_pc_o, 32'd0);
        checkOutput("rst_id_instr", ID_instr_o, 32'd0);
        checkOutput("rst_id_ghr",   32'(ID_ghr_data_o), 32'd0);
        settle();
        checkOutput("rst_req_held", 32'(imem_req_o), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("rst_perf_fetch",    perf_fetch_cnt_o, 32'd0);
        checkOutput("rst_perf_redirect", perf_redirect_cnt_o, 32'd0);
`endif
        rst_i = 1'b0;

        // Table-driven fetch stream
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end
`ifdef FETCH_PERF_CNT_EN
        checkOutput("perf_fetch_after_table",    perf_fetch_cnt_o, 32'd9);
        checkOutput("perf_redirect_after_table", perf_redirect_cnt_o, 32'd0);
`endif

        // Flush during WAIT: response arrives two cycles later and is dropped
        idleInputs();
        waitReq(32'h4, "flushwait", waited, ok);
        tick();
        IF_flush_i        = 1'b1;
        IF_PCnext_sel_i   = 2'b11;
        EXMEM_br_target_i = 32'h0000_0100;
        EXMEM_pcplus4_i   = 32'h0000_0008;
        settle();
        checkOutput("flushwait_noreq", 32'(imem_req_o), 32'd0);
        tick();
        idleInputs();
        checkOutput("flushwait_id_valid", 32'(ID_valid_o), 32'd0);
        checkOutput("flushwait_pc",       IF_pc_o, 32'h0000_0100);
        settle();
        checkOutput("flushwait_discard_noreq", 32'(imem_req_o), 32'd0);
        tick();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        tick();
        idleInputs();
        checkOutput("flushwait_dropped", 32'(ID_valid_o), 32'd0);
        checkOutput("flushwait_pc_kept", IF_pc_o, 32'h0000_0100);
        applyStimulus('{2'b00, 1'b0, 1'b0, 8'h99, 32'h0, 1, 32'h0000_0100}, "after_flush");

        // Stall into HOLD for three cycles, then release
        idleInputs();
        IF_prediction_i = 1'b1;
        IF_ghr_data_i   = 8'hA7;
        ID_stall_i      = 1'b1;
        waitReq(32'h0000_0104, "hold", waited, ok);
        sb.push_back('{32'h0000_0104, mem_word(32'h0000_0104), 1'b1, 1'b0, 8'hA7});
        tick();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(32'h0000_0104);
        tick();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        checkOutput("hold_id_kept_pc",    ID_pc_o, 32'h0000_0100);
        checkOutput("hold_id_kept_valid", 32'(ID_valid_o), 32'd1);
        settle();
        checkOutput("hold_noreq_a", 32'(imem_req_o), 32'd0);
        tick();
        ID_stall_i = 1'b0;
        settle();
        checkOutput("hold_noreq_b", 32'(imem_req_o), 32'd0);
        tick();
        popCompare("hold_release");
        settle();
        checkOutput("hold_next_req",  32'(imem_req_o), 32'd1);
        checkOutput("hold_next_addr", imem_addr_o, 32'h0000_0108);
        tick();
        checkOutput("bubble_after_hold", 32'(ID_valid_o), 32'd0);

        // Flush + stall + rvalid together while in WAIT: flush wins
        IF_flush_i        = 1'b1;
        ID_stall_i        = 1'b1;
        imem_rvalid_i     = 1'b1;
        imem_rdata_i      = 32'h1234_5678;
        IF_PCnext_sel_i   = 2'b01;
        EXMEM_pcplus4_i   = 32'h0000_0024;
        EXMEM_br_target_i = 32'h0000_0200;
        tick();
        idleInputs();
        checkOutput("collide_id_valid", 32'(ID_valid_o), 32'd0);
        checkOutput("collide_pc",       IF_pc_o, 32'h0000_0024);
        settle();
        checkOutput("collide_idle_req", 32'(imem_req_o), 32'd1);
        applyStimulus('{2'b00, 1'b1, 1'b1, 8'h3C, 32'h0, 1, 32'h0000_0024}, "after_collide");

        // Reset in the middle of WAIT, then a stale response
        idleInputs();
        waitReq(32'h0000_0028, "rstwait", waited, ok);
        tick();
        rst_i = 1'b1;
        settle();
        checkOutput("rstwait_req_in_reset", 32'(imem_req_o), 32'd0);
        tick();
        rst_i         = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hBADB_AD00;
        settle();
        checkOutput("rstwait_first_req",  32'(imem_req_o), 32'd1);
        checkOutput("rstwait_first_addr", imem_addr_o, RST_PC);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("rstwait_perf_fetch",    perf_fetch_cnt_o, 32'd0);
        checkOutput("rstwait_perf_redirect", perf_redirect_cnt_o, 32'd0);
`endif
        sb.push_back('{RST_PC, mem_word(RST_PC), 1'b0, 1'b0, 8'h00});
        tick();
        checkOutput("rstwait_stale_ignored", 32'(ID_valid_o), 32'd0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(RST_PC);
        tick();
        idleInputs();
        popCompare("rstwait_refetch");

        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
